// File: rtl/calc_pkg.sv
// Shared definitions for the hex calculator front-end: operator codes,
// key indices, decoder FSM states and per-scan classification.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam logic [4:0] KEY_ADD = 5'd16;
    localparam logic [4:0] KEY_MUL = 5'd17;
    localparam logic [4:0] KEY_SUB = 5'd18;
    localparam logic [4:0] KEY_EQ  = 5'd19;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_class_e;

    function automatic logic [1:0] key_to_opcode(input logic [4:0] key);
        case (key)
            KEY_MUL: return OP_MUL;
            KEY_SUB: return OP_SUB;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Key event bus between the keypad decoder and the operand register stage,
// plus the decoder FSM state for observation.
interface keypad_decoder_if;
    import calc_pkg::*;

    // newhex/newop/eq are single-cycle valids with no ready: the consumer must
    // take the event in the cycle it is presented; hexcode/opcode hold afterwards.
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;
    logic       key_held;
    kp_state_e  fsm_state;

    modport master (output newhex, hexcode, newop, opcode, eq, key_held, fsm_state);
    modport slave  (input  newhex, hexcode, newop, opcode, eq, key_held, fsm_state);

endinterface

// File: rtl/keypad_row_scanner.sv
// Drives one keypad row low at a time, synchronises the columns and
// classifies each full five-row scan as NONE, SINGLE(key) or MULTI.
module keypad_row_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col_n_i,
    output logic [4:0]  row_n_o,
    output logic        scan_done_o,
    output scan_class_e scan_class_o,
    output logic [4:0]  scan_key_o
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    row_q, row_d;
    logic [3:0]    meta_q, sync_q;
    logic [1:0]    hits_q, hits_d;
    logic [4:0]    key_q, key_d;
    logic          done_q, done_d;
    scan_class_e   class_q, class_d;
    logic [4:0]    key_out_q, key_out_d;

    logic [3:0] row_low;
    logic [2:0] row_hits;
    logic [2:0] total;
    logic [1:0] col_idx;
    logic [4:0] key_here;
    logic       dwell_end;

    always_ff @(posedge clock) begin
        if (!reset) begin
            dwell_q   <= '0;
            row_q     <= '0;
            meta_q    <= 4'hF;
            sync_q    <= 4'hF;
            hits_q    <= '0;
            key_q     <= '0;
            done_q    <= 1'b0;
            class_q   <= NONE;
            key_out_q <= '0;
        end else begin
            dwell_q   <= dwell_d;
            row_q     <= row_d;
            meta_q    <= col_n_i;
            sync_q    <= meta_q;
            hits_q    <= hits_d;
            key_q     <= key_d;
            done_q    <= done_d;
            class_q   <= class_d;
            key_out_q <= key_out_d;
        end
    end

    assign row_low   = ~sync_q;
    assign row_hits  = 3'($countones(row_low));
    assign total     = {1'b0, hits_q} + row_hits;
    assign key_here  = {row_q, col_idx};
    assign dwell_end = (dwell_q == DW'(SCAN_DIV - 1));

    always_comb begin
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (row_low[c]) col_idx = 2'(c);
        end
    end

    // Hits saturate at 2: beyond that only "more than one" matters.
    always_comb begin
        dwell_d   = dwell_q + DW'(1);
        row_d     = row_q;
        hits_d    = hits_q;
        key_d     = key_q;
        done_d    = 1'b0;
        class_d   = class_q;
        key_out_d = key_out_q;
        if (dwell_end) begin
            dwell_d = '0;
            hits_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
            if (row_hits == 3'd1) key_d = key_here;
            if (row_q == 3'd4) begin
                row_d     = '0;
                done_d    = 1'b1;
                class_d   = (total == 3'd0) ? NONE : (total == 3'd1) ? SINGLE : MULTI;
                key_out_d = (row_hits == 3'd1) ? key_here : key_q;
                hits_d    = '0;
                key_d     = '0;
            end else begin
                row_d = row_q + 3'd1;
            end
        end
    end

    assign row_n_o      = ~(5'b00001 << row_q);
    assign scan_done_o  = done_q;
    assign scan_class_o = class_q;
    assign scan_key_o   = key_out_q;

endmodule

// File: rtl/keypad_decoder.sv
// Debounces scan results from the row scanner and turns each accepted press
// into one single-cycle newhex/newop/eq event.
module keypad_decoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        col_n,
    output logic [4:0]        row_n,
    keypad_decoder_if.master  kp
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic        scan_done;
    scan_class_e scan_class;
    logic [4:0]  scan_key;

    keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clock        (clock),
        .reset        (reset),
        .col_n_i      (col_n),
        .row_n_o      (row_n),
        .scan_done_o  (scan_done),
        .scan_class_o (scan_class),
        .scan_key_o   (scan_key)
    );

    kp_state_e   state_q, state_d;
    logic [4:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic        newhex_q, newhex_d;
    logic        newop_q, newop_d;
    logic        eq_q, eq_d;
    logic [3:0]  hexcode_q, hexcode_d;
    logic [1:0]  opcode_q, opcode_d;
    logic        accept;
    logic [CW-1:0] cnt_step;
    logic        cnt_full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            newhex_q  <= 1'b0;
            newop_q   <= 1'b0;
            eq_q      <= 1'b0;
            hexcode_q <= 4'h0;
            opcode_q  <= OP_ADD;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            newhex_q  <= newhex_d;
            newop_q   <= newop_d;
            eq_q      <= eq_d;
            hexcode_q <= hexcode_d;
            opcode_q  <= opcode_d;
        end
    end

    assign cnt_step = cnt_q + CW'(1);
    assign cnt_full = (cnt_step == CW'(DEBOUNCE_SCANS));

    // armed_q stays low after reset until an empty scan is seen, so a key held
    // through reset is not accepted until it has been released.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        accept  = 1'b0;
        if (scan_done) begin
            if (scan_class == NONE) armed_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (scan_class == SINGLE && armed_q) begin
                        state_d = DEBOUNCE;
                        cand_d  = scan_key;
                        cnt_d   = CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (scan_class == SINGLE && scan_key == cand_q) begin
                        if (cnt_full) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_step;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (scan_class == NONE) begin
                        if (cnt_full) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_step;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        newhex_d  = accept && (cand_q < KEY_ADD);
        newop_d   = accept && (cand_q >= KEY_ADD) && (cand_q != KEY_EQ);
        eq_d      = accept && (cand_q == KEY_EQ);
        hexcode_d = newhex_d ? cand_q[3:0] : hexcode_q;
        opcode_d  = newop_d ? key_to_opcode(cand_q) : opcode_q;
    end

    assign kp.newhex    = newhex_q;
    assign kp.hexcode   = hexcode_q;
    assign kp.newop     = newop_q;
    assign kp.opcode    = opcode_q;
    assign kp.eq        = eq_q;
    assign kp.key_held  = (state_q == HELD);
    assign kp.fsm_state = state_q;

endmodule
